knn_batch_sched: RTL

- Batch controller sitting between the host/test harness and the HLS `knn_top` core.
- Walks a packed image buffer (`IMG_SIZE` bytes per image), relocates the core's two image read ports onto the current image, and runs `ap_start`/`ap_ready`/`ap_done` once per image.
- Per image: captures the predicted label, compares it against a stored label, writes a result record, and accumulates the correct-prediction count.
- Replaces the testbench-driven per-image loop with synthesizable sequencing.

---
 rtl/knn_pkg.sv | 22 ++
 rtl/knn_addr_reloc.sv | 62 ++++++
 rtl/knn_batch_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// Shared constants and types for the knn_top batch scheduler.
package knn_pkg;

    localparam int IMG_SIZE = 784;
    localparam int LBL_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        START,
        RUN,
        CHECK,
        FIN
    } sched_state_t;

    typedef struct packed {
        logic             timeout;
        logic             match;
        logic [LBL_W-1:0] pred;
    } knn_res_t;

endpackage

// File: rtl/knn_addr_reloc.sv
// Relocates the core's two image read ports onto the current image of the packed buffer.
module knn_addr_reloc
    import knn_pkg::*;
#(
    parameter int IMG_SIZE = knn_pkg::IMG_SIZE,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              base_clr_i,
    input  logic              base_adv_i,
    input  logic              run_i,
    input  logic [9:0]        knn_addr0_i,
    input  logic [9:0]        knn_addr1_i,
    input  logic              knn_ce0_i,
    input  logic              knn_ce1_i,
    output logic [ADDR_W-1:0] mem_addr0_o,
    output logic [ADDR_W-1:0] mem_addr1_o,
    output logic              mem_ce0_o,
    output logic              mem_ce1_o
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [9:0]        port_addr [2];
    logic              port_ce   [2];
    logic [ADDR_W-1:0] mem_addr  [2];
    logic              mem_ce    [2];

    assign port_addr[0] = knn_addr0_i;
    assign port_addr[1] = knn_addr1_i;
    assign port_ce[0]   = knn_ce0_i;
    assign port_ce[1]   = knn_ce1_i;

    always_comb begin
        base_d = base_q;
        if (base_clr_i) begin
            base_d = '0;
        end else if (base_adv_i) begin
            base_d = base_q + ADDR_W'(IMG_SIZE);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    // Reads are only let through while the core is actually running an image.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign mem_addr[gi] = base_q + ADDR_W'(port_addr[gi]);
        assign mem_ce[gi]   = port_ce[gi] & run_i;
    end

    assign mem_addr0_o = mem_addr[0];
    assign mem_addr1_o = mem_addr[1];
    assign mem_ce0_o   = mem_ce[0];
    assign mem_ce1_o   = mem_ce[1];

endmodule

// File: rtl/knn_batch_sched.sv
// Batch sequencer for knn_top: one ap_start/ap_done round per image, result records and score.
// Optional watchdog on the RUN phase is enabled with `define KNN_TIMEOUT_EN.
module knn_batch_sched
    import knn_pkg::*;
#(
    parameter int IMG_SIZE    = knn_pkg::IMG_SIZE,
    parameter int ADDR_W      = 17,
    parameter int MAX_IMG     = 100,
    parameter int IDX_W       = 7,
    parameter int LBL_W       = knn_pkg::LBL_W,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              cmd_start,
    input  logic [IDX_W:0]    cmd_len,
    output logic              busy,
    output logic              batch_done,
    output logic [IDX_W:0]    correct_cnt,
    output logic              knn_start,
    input  logic              knn_ready,
    input  logic              knn_done,
    input  logic              knn_idle,
    input  logic [31:0]       knn_result,
    input  logic              knn_result_vld,
    input  logic [9:0]        knn_addr0,
    input  logic [9:0]        knn_addr1,
    input  logic              knn_ce0,
    input  logic              knn_ce1,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic              mem_ce0,
    output logic              mem_ce1,
    output logic [IDX_W-1:0]  lbl_addr,
    input  logic [LBL_W-1:0]  lbl_q,
    output logic              res_we,
    output logic [IDX_W-1:0]  res_addr,
    output logic [LBL_W+1:0]  res_data
);

    localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(MAX_IMG);

    sched_state_t     state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_q, start_d;
    logic             res_we_q, res_we_d;
    logic             pred_vld_q, pred_vld_d;
    logic             tmo_q, tmo_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] res_addr_q, res_addr_d;
    logic [IDX_W-1:0] lbl_addr_q, lbl_addr_d;
    logic [LBL_W-1:0] pred_q, pred_d;
    knn_res_t         res_q, res_d;
    logic             base_clr, base_adv, match, tmo_hit;
    logic [IDX_W:0]   len_clamped;
    logic             unused_result_bits;

    assign unused_result_bits = ^knn_result[31:LBL_W];
    assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

`ifdef KNN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst || state_q != RUN) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    assign tmo_hit = (state_q == RUN) && !knn_done && (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        start_d    = start_q;
        res_we_d   = 1'b0;
        pred_vld_d = pred_vld_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        idx_d      = idx_q;
        res_addr_d = res_addr_q;
        lbl_addr_d = lbl_addr_q;
        pred_d     = pred_q;
        res_d      = res_q;
        base_clr   = 1'b0;
        base_adv   = 1'b0;
        match      = pred_vld_q & ~tmo_q & (pred_q == lbl_q);

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    len_d      = len_clamped;
                    cnt_d      = '0;
                    idx_d      = '0;
                    pred_vld_d = 1'b0;
                    tmo_d      = 1'b0;
                    base_clr   = 1'b1;
                    if (len_clamped == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = WAIT_IDLE;
                        busy_d  = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (knn_idle) begin
                    state_d = START;
                    start_d = 1'b1;
                end
            end
            START: begin
                if (knn_ready) begin
                    state_d    = RUN;
                    start_d    = 1'b0;
                    lbl_addr_d = idx_q;
                end
            end
            RUN: begin
                // A result strobe coinciding with ap_done is still captured.
                if (knn_result_vld) begin
                    pred_d     = knn_result[LBL_W-1:0];
                    pred_vld_d = 1'b1;
                end
                if (knn_done) begin
                    state_d = CHECK;
                end else if (tmo_hit) begin
                    state_d = CHECK;
                    tmo_d   = 1'b1;
                end
            end
            CHECK: begin
                res_we_d      = 1'b1;
                res_addr_d    = idx_q;
                res_d.timeout = tmo_q;
                res_d.match   = match;
                res_d.pred    = (pred_vld_q && !tmo_q) ? pred_q : '1;
                if (match && cnt_q != MAX_LEN) begin
                    cnt_d = cnt_q + (IDX_W+1)'(1);
                end
                idx_d      = idx_q + IDX_W'(1);
                base_adv   = 1'b1;
                pred_vld_d = 1'b0;
                tmo_d      = 1'b0;
                state_d    = ({1'b0, idx_q} + (IDX_W+1)'(1) == len_q) ? FIN : WAIT_IDLE;
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            res_we_q   <= 1'b0;
            pred_vld_q <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            res_addr_q <= '0;
            lbl_addr_q <= '0;
            pred_q     <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            start_q    <= start_d;
            res_we_q   <= res_we_d;
            pred_vld_q <= pred_vld_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            res_addr_q <= res_addr_d;
            lbl_addr_q <= lbl_addr_d;
            pred_q     <= pred_d;
            res_q      <= res_d;
        end
    end

    knn_addr_reloc #(
        .IMG_SIZE (IMG_SIZE),
        .ADDR_W   (ADDR_W)
    ) u_reloc (
        .clk         (ap_clk),
        .srst        (ap_rst),
        .base_clr_i  (base_clr),
        .base_adv_i  (base_adv),
        .run_i       (state_q == RUN),
        .knn_addr0_i (knn_addr0),
        .knn_addr1_i (knn_addr1),
        .knn_ce0_i   (knn_ce0),
        .knn_ce1_i   (knn_ce1),
        .mem_addr0_o (mem_addr0),
        .mem_addr1_o (mem_addr1),
        .mem_ce0_o   (mem_ce0),
        .mem_ce1_o   (mem_ce1)
    );

    assign busy        = busy_q;
    assign batch_done  = done_q;
    assign correct_cnt = cnt_q;
    assign knn_start   = start_q;
    assign lbl_addr    = lbl_addr_q;
    assign res_we      = res_we_q;
    assign res_addr    = res_addr_q;
    assign res_data    = res_q;

endmodule
